// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among num_req_p valid/ready
// requesters. A grant lasts one packet or at most burst_len_p beats, and an
// idle bubble cycle separates consecutive grants. The data path is a pure
// combinational mux; only the grant/pointer/beat-count control is registered.
module fifo_rr_arbiter #(
  parameter int width_p     = 32,
  parameter int num_req_p   = 4,
  parameter int burst_len_p = 8
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [num_req_p-1:0]           valid_i,
  input  logic [num_req_p*width_p-1:0]   data_i,
  input  logic [num_req_p-1:0]           last_i,
  output logic [num_req_p-1:0]           ready_o,
  output logic                           valid_o,
  output logic [width_p-1:0]             data_o,
  output logic                           last_o,
  input  logic                           ready_i,
  output logic [num_req_p-1:0]           grant_o,
  output logic                           burst_end_o
);

  localparam int idx_w = $clog2(num_req_p);
  localparam int cnt_w = $clog2(burst_len_p + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [idx_w-1:0] gidx_q, gidx_d;
  logic [idx_w-1:0] rr_ptr_q, rr_ptr_d;
  logic [cnt_w-1:0] beat_cnt_q, beat_cnt_d;
  logic [idx_w-1:0] pick_idx;
  logic             pick_vld;
  logic             hs;
  logic             at_limit;

  // Find the first valid requester at or after rr_ptr, wrapping around;
  // iterating offsets high-to-low lets the smallest offset win.
  always_comb begin : pick_search
    int c;
    pick_vld = 1'b0;
    pick_idx = '0;
    c        = 0;
    for (int k = num_req_p - 1; k >= 0; k--) begin
      c = int'(rr_ptr_q) + k;
      if (c >= num_req_p) c = c - num_req_p;
      if (valid_i[c]) begin
        pick_vld = 1'b1;
        pick_idx = idx_w'(c);
      end
    end
  end

  // Grant-state register; async reset drops any grant at once.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      gidx_q     <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gidx_q     <= gidx_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Output mux for the granted requester plus next-state/release decision.
  always_comb begin
    state_d     = state_q;
    gidx_d      = gidx_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    grant_o     = '0;
    ready_o     = '0;
    valid_o     = 1'b0;
    data_o      = '0;
    last_o      = 1'b0;
    burst_end_o = 1'b0;
    hs          = 1'b0;
    at_limit    = (beat_cnt_q == cnt_w'(burst_len_p - 1));

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d    = BUSY;
          gidx_d     = pick_idx;
          beat_cnt_d = '0;
        end
      end
      BUSY: begin
        grant_o[gidx_q] = 1'b1;
        valid_o         = valid_i[gidx_q];
        data_o          = data_i[int'(gidx_q)*width_p +: width_p];
        last_o          = last_i[gidx_q];
        ready_o[gidx_q] = ready_i;
        hs              = valid_o & ready_i;
        if (hs) begin
          if (last_o || at_limit) begin
            // Packet end or beat limit: release and move the pointer past g.
            burst_end_o = 1'b1;
            state_d     = IDLE;
            beat_cnt_d  = '0;
            rr_ptr_d    = (gidx_q == idx_w'(num_req_p - 1)) ? '0 : gidx_q + 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Bench for fifo_rr_arbiter: two instances (burst_len_p 8 and 1) share the
// same stimulus and are compared every cycle against a grant-level model.
module tb_fifo_rr_arbiter;

  localparam int W = 32;
  localparam int N = 4;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic [N-1:0]     valid_i;
  logic [N*W-1:0]   data_i;
  logic [N-1:0]     last_i;
  logic             ready_i;

  logic [N-1:0]     ready_o0, grant_o0, ready_o1, grant_o1;
  logic             valid_o0, last_o0, be_o0, valid_o1, last_o1, be_o1;
  logic [W-1:0]     data_o0, data_o1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state per instance: owner -1 means no grant.
  int owner[2];
  int ptr[2];
  int beats[2];
  int bl[2];
  bit hs_m[2];
  bit end_m[2];
  int be_cnt0;

  fifo_rr_arbiter #(.width_p(W), .num_req_p(N), .burst_len_p(8)) dut0 (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .data_i(data_i),
    .last_i(last_i), .ready_o(ready_o0), .valid_o(valid_o0), .data_o(data_o0),
    .last_o(last_o0), .ready_i(ready_i), .grant_o(grant_o0), .burst_end_o(be_o0)
  );

  fifo_rr_arbiter #(.width_p(W), .num_req_p(N), .burst_len_p(1)) dut1 (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .data_i(data_i),
    .last_i(last_i), .ready_o(ready_o1), .valid_o(valid_o1), .data_o(data_o1),
    .last_o(last_o1), .ready_i(ready_i), .grant_o(grant_o1), .burst_end_o(be_o1)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      owner[i] = -1;
      ptr[i]   = 0;
      beats[i] = 0;
    end
  endtask

  task automatic check_inst(input int i, input logic [N-1:0] g, input logic [N-1:0] r,
                            input logic v, input logic l, input logic e, input logic [W-1:0] d);
    logic [N-1:0] eg, er;
    logic         ev, el, ee;
    logic [W-1:0] ed;
    int           o;
    o = owner[i];
    eg = '0; er = '0; ev = 1'b0; el = 1'b0; ee = 1'b0; ed = '0;
    if (o >= 0) begin
      eg[o] = 1'b1;
      ev    = valid_i[o];
      ed    = data_i[o*W +: W];
      el    = last_i[o];
      er[o] = ready_i;
      ee    = ev && ready_i && (last_i[o] || (beats[i] == bl[i] - 1));
    end
    hs_m[i]  = ev && ready_i;
    end_m[i] = ee;
    check_val($sformatf("grant%0d", i), g, eg);
    check_val($sformatf("ready%0d", i), r, er);
    check_val($sformatf("valid%0d", i), v, ev);
    check_val($sformatf("last%0d", i), l, el);
    check_val($sformatf("burst_end%0d", i), e, ee);
    check_val($sformatf("data%0d", i), d, ed);
  endtask

  task automatic update_model();
    for (int i = 0; i < 2; i++) begin
      if (owner[i] < 0) begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (ptr[i] + k) % N;
          if (valid_i[c]) begin
            owner[i] = c;
            beats[i] = 0;
            break;
          end
        end
      end else if (hs_m[i]) begin
        if (end_m[i]) begin
          ptr[i]   = (owner[i] + 1) % N;
          owner[i] = -1;
          beats[i] = 0;
        end else begin
          beats[i]++;
        end
      end
    end
  endtask

  // One cycle: inputs already driven; check at negedge, advance model at posedge.
  task automatic step();
    @(negedge clk_i);
    check_inst(0, grant_o0, ready_o0, valid_o0, last_o0, be_o0, data_o0);
    check_inst(1, grant_o1, ready_o1, valid_o1, last_o1, be_o1, data_o1);
    if (be_o0) be_cnt0++;
    @(posedge clk_i);
    if (!reset_i) update_model();
    #1;
  endtask

  task automatic rand_data();
    for (int r = 0; r < N; r++) data_i[r*W +: W] = $urandom;
  endtask

  initial begin
    bl[0] = 8;
    bl[1] = 1;
    model_reset();
    reset_i = 1'b1;
    valid_i = '0;
    last_i  = '0;
    data_i  = '0;
    ready_i = 1'b0;
    #2;
    check_val("rst_grant", grant_o0, 0);
    check_val("rst_valid", valid_o0, 0);
    check_val("rst_ready", ready_o0, 0);
    check_val("rst_be", be_o0, 0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;

    // Single requester 0, packet of three beats.
    valid_i = 4'b0001; ready_i = 1'b1; rand_data();
    be_cnt0 = 0;
    for (int s = 0; s < 5; s++) begin
      last_i = (s == 3) ? 4'b0001 : 4'b0000;
      if (s == 4) valid_i = '0;
      step();
      data_i[0 +: W] = $urandom;
    end
    check_val("t1_bursts", be_cnt0, 1);

    // All requesters valid, no last: full-length bursts in rotation.
    valid_i = 4'b1111; last_i = '0; ready_i = 1'b1; rand_data();
    be_cnt0 = 0;
    repeat (45) step();
    check_val("t2_bursts", be_cnt0, 5);
    valid_i = '0;
    repeat (2) step();

    // Requester 2 alone with ready toggling.
    valid_i = 4'b0100; rand_data();
    for (int s = 0; s < 12; s++) begin
      ready_i = s[0];
      step();
    end
    valid_i = '0; ready_i = 1'b1;
    repeat (10) step();

    // Requester 1 granted, then drops valid while requester 3 waits.
    valid_i = 4'b0010; rand_data();
    step();
    valid_i = 4'b1010;
    repeat (2) step();
    valid_i = 4'b1000;
    repeat (5) step();
    valid_i = 4'b1010; last_i = 4'b0010;
    repeat (12) step();
    last_i = '0;
    valid_i = 4'b0010;
    repeat (3) step();

    // Asynchronous reset in the middle of a burst.
    #3;
    reset_i = 1'b1;
    #1;
    check_val("arst_valid", valid_o0, 0);
    check_val("arst_ready", ready_o0, 0);
    check_val("arst_grant", grant_o0, 0);
    model_reset();
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    valid_i = 4'b1000;
    repeat (4) step();
    valid_i = '0;
    repeat (10) step();

    // Two requesters, watch the single-beat instance alternate.
    valid_i = 4'b0101; rand_data();
    repeat (12) step();
    valid_i = '0;
    repeat (10) step();

    // Randomized traffic.
    for (int s = 0; s < 3000; s++) begin
      for (int r = 0; r < N; r++) begin
        if (!valid_i[r] || owner[0] == r || owner[1] == r) begin
          valid_i[r]       = ($urandom_range(0, 9) < 7);
          last_i[r]        = ($urandom_range(0, 3) == 0);
          data_i[r*W +: W] = $urandom;
        end
      end
      ready_i = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
